// File: rtl/ptosda_n.sv
// Parallel-to-serial start/data/stop framer driving an scl/sda pair.
// Build option: define PTOSDA_PARITY_EN to append an even-parity bit after the data bits.
module ptosda_n #(
  parameter int DW = 8
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          valid,
  output logic          ready,
  output logic          scl,
  output logic          sda,
  output logic          busy,
  output logic          done
);

  localparam int IW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] BIT   = 3'd2;
`ifdef PTOSDA_PARITY_EN
  localparam logic [2:0] PAR   = 3'd3;
`endif
  localparam logic [2:0] STOP  = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic          phase_reg, phase_next;
  logic [1:0]    stop_cnt_reg, stop_cnt_next;
  logic [IW-1:0] bit_idx_reg, bit_idx_next;
  logic [DW-1:0] shift_reg, shift_next;

  logic scl_reg, scl_next;
  logic sda_reg, sda_next;
  logic ready_reg, ready_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;

`ifdef PTOSDA_PARITY_EN
  logic          parity_reg, parity_next;
  logic [DW:0]   par_chain;

  assign par_chain[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < DW; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ data_in[gi];
    end
  endgenerate
`endif

  // Outputs are computed from the next state and registered alongside it.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      phase_reg    <= 1'b0;
      stop_cnt_reg <= 2'd0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      scl_reg      <= 1'b1;
      sda_reg      <= 1'b1;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef PTOSDA_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      stop_cnt_reg <= stop_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      scl_reg      <= scl_next;
      sda_reg      <= sda_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
`ifdef PTOSDA_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    stop_cnt_next = stop_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
`ifdef PTOSDA_PARITY_EN
    parity_next   = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (valid && ready_reg) begin
          state_next = START;
          shift_next = data_in;
`ifdef PTOSDA_PARITY_EN
          parity_next = par_chain[DW];
`endif
        end
      end
      START: begin
        state_next   = BIT;
        phase_next   = 1'b0;
        bit_idx_next = IW'(DW - 1);
      end
      BIT: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else if (bit_idx_reg == '0) begin
          phase_next = 1'b0;
`ifdef PTOSDA_PARITY_EN
          state_next = PAR;
`else
          state_next    = STOP;
          stop_cnt_next = 2'd0;
`endif
        end else begin
          // MSB always sits at the top of the shift register.
          phase_next   = 1'b0;
          bit_idx_next = bit_idx_reg - 1'b1;
          shift_next   = {shift_reg[DW-2:0], 1'b0};
        end
      end
`ifdef PTOSDA_PARITY_EN
      PAR: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next    = 1'b0;
          state_next    = STOP;
          stop_cnt_next = 2'd0;
        end
      end
`endif
      STOP: begin
        if (stop_cnt_reg == 2'd2) begin
          state_next    = IDLE;
          stop_cnt_next = 2'd0;
        end else begin
          stop_cnt_next = stop_cnt_reg + 2'd1;
        end
      end
      default: begin
        state_next    = IDLE;
        phase_next    = 1'b0;
        stop_cnt_next = 2'd0;
      end
    endcase
  end

  always_comb begin
    scl_next   = 1'b1;
    sda_next   = 1'b1;
    ready_next = 1'b1;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_next)
      IDLE: begin
        done_next = (state_reg == STOP);
      end
      START: begin
        sda_next   = 1'b0;
        ready_next = 1'b0;
        busy_next  = 1'b1;
      end
      BIT: begin
        scl_next   = phase_next;
        sda_next   = shift_next[DW-1];
        ready_next = 1'b0;
        busy_next  = 1'b1;
      end
`ifdef PTOSDA_PARITY_EN
      PAR: begin
        scl_next   = phase_next;
        sda_next   = parity_next;
        ready_next = 1'b0;
        busy_next  = 1'b1;
      end
`endif
      STOP: begin
        ready_next = 1'b0;
        busy_next  = 1'b1;
        case (stop_cnt_next)
          2'd0: begin
            scl_next = 1'b0;
            sda_next = 1'b0;
          end
          2'd1: begin
            scl_next = 1'b1;
            sda_next = 1'b0;
          end
          default: begin
            scl_next = 1'b1;
            sda_next = 1'b1;
          end
        endcase
      end
      default: begin
        scl_next = 1'b1;
      end
    endcase
  end

  assign scl   = scl_reg;
  assign sda   = sda_reg;
  assign ready = ready_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_ptosda_n.sv
// Randomized framing checks for ptosda_n (DW=8 and DW=4) against a per-cycle frame model.
module tb_ptosda_n;

  logic       sclk;
  logic       rst;
  logic [7:0] data8;
  logic       valid8;
  logic       ready8, scl8, sda8, busy8, done8;
  logic [3:0] data4;
  logic       valid4;
  logic       ready4, scl4, sda4, busy4, done4;

  int checks;
  int errors;

  // Expected {scl,sda,ready,busy,done} per cycle after the accepting edge.
  logic [4:0]  exp_q[$];
  logic [31:0] word_q[$];

`ifdef PTOSDA_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [4:0] IDLE_VEC = 5'b11100;

  ptosda_n #(.DW(8)) u8 (
    .sclk(sclk), .rst(rst), .data_in(data8), .valid(valid8),
    .ready(ready8), .scl(scl8), .sda(sda8), .busy(busy8), .done(done8)
  );

  ptosda_n #(.DW(4)) u4 (
    .sclk(sclk), .rst(rst), .data_in(data4), .valid(valid4),
    .ready(ready4), .scl(scl4), .sda(sda4), .busy(busy4), .done(done4)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  function automatic logic [4:0] obs(input bit sel);
    return sel ? {scl4, sda4, ready4, busy4, done4} : {scl8, sda8, ready8, busy8, done8};
  endfunction

  task automatic check_vec(input logic [4:0] o, input logic [4:0] e, input string tag);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  // Frame built directly from the line protocol: start, MSB-first bit pairs, optional parity, stop, done.
  task automatic push_frame(input logic [31:0] w, input int dw);
    logic p;
    p = 1'b0;
    exp_q.push_back(5'b10010);
    for (int i = dw - 1; i >= 0; i--) begin
      exp_q.push_back({1'b0, w[i], 3'b010});
      exp_q.push_back({1'b1, w[i], 3'b010});
      p = p ^ w[i];
    end
    if (PAR_EN) begin
      exp_q.push_back({1'b0, p, 3'b010});
      exp_q.push_back({1'b1, p, 3'b010});
    end
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b10010);
    exp_q.push_back(5'b11010);
    exp_q.push_back(5'b11101);
  endtask

  task automatic start_frame(input bit sel, input logic [31:0] w);
    push_frame(w, sel ? 4 : 8);
    word_q.push_back(w);
    if (sel) begin
      data4  = w[3:0];
      valid4 = 1'b1;
    end else begin
      data8  = w[7:0];
      valid8 = 1'b1;
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge sclk); #1;
      check_vec(obs(1'b0), IDLE_VEC, tag);
      check_vec(obs(1'b1), IDLE_VEC, tag);
    end
  endtask

  // mode 0: random data/valid noise while busy; 1: hold valid with next_w; 2: next_w with valid noise.
  task automatic run_checks(input bit sel, input int mode, input logic [31:0] next_w,
                            input int limit, input string tag);
    logic [4:0]  e, o;
    logic        prev_scl;
    logic        bits[$];
    logic [31:0] dec, wq;
    logic        p, v;
    logic [31:0] d;
    int          n, dw;
    dw = sel ? 4 : 8;
    prev_scl = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      e = exp_q.pop_front();
      n++;
      @(posedge sclk); #1;
      o = obs(sel);
      check_vec(o, e, $sformatf("%s cycle %0d", tag, n));
      if (!prev_scl && o[4]) bits.push_back(o[3]);
      prev_scl = o[4];
      if (o[0]) begin
        wq = (word_q.size() > 0) ? word_q.pop_front() : 32'hxxxxxxxx;
        dec = 32'd0;
        for (int i = 0; i < dw; i++)
          dec = {dec[30:0], (i < bits.size()) ? bits[i] : 1'bx};
        checks++;
        assert (dec === wq) else begin
          errors++;
          $error("FAIL %s decoded word: observed %h expected %h", tag, dec, wq);
        end
        if (PAR_EN) begin
          p = 1'b0;
          for (int i = 0; i < dw; i++) p = p ^ wq[i];
          checks++;
          assert (bits.size() > dw && bits[dw] === p) else begin
            errors++;
            $error("FAIL %s parity bit: observed %b expected %b", tag,
                   (bits.size() > dw) ? bits[dw] : 1'bx, p);
          end
        end
        bits.delete();
      end
      case (mode)
        1: begin
          d = next_w;
          v = (exp_q.size() != 0);
        end
        2: begin
          d = next_w;
          v = e[2] ? 1'b0 : 1'($urandom_range(0, 1));
        end
        default: begin
          d = $urandom;
          v = e[2] ? 1'b0 : 1'($urandom_range(0, 1));
        end
      endcase
      if (sel) begin
        data4  = d[3:0];
        valid4 = v;
      end else begin
        data8  = d[7:0];
        valid8 = v;
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    valid8 = 1'b0;
    valid4 = 1'b0;
    data8  = 8'h00;
    data4  = 4'h0;

    #2 rst = 1'b0;
    #1;
    check_vec(obs(1'b0), IDLE_VEC, "reset u8");
    check_vec(obs(1'b1), IDLE_VEC, "reset u4");
    repeat (2) @(posedge sclk);
    #1 rst = 1'b1;
    idle_check(10, "idle after reset");

    start_frame(1'b0, 32'hA5);
    run_checks(1'b0, 0, 32'd0, 1000, "frame A5");
    idle_check(2, "idle after A5");

    for (int r = 0; r < 4; r++) begin
      w = $urandom & 32'hFF;
      start_frame(1'b0, w);
      run_checks(1'b0, 0, 32'd0, 1000, $sformatf("rand frame %0d", r));
      idle_check($urandom_range(1, 3), "idle gap");
    end

    start_frame(1'b0, 32'h3C);
    push_frame(32'hC3, 8);
    word_q.push_back(32'hC3);
    run_checks(1'b0, 1, 32'hC3, 1000, "back-to-back");
    idle_check(2, "idle after b2b");

    start_frame(1'b0, 32'h07);
    run_checks(1'b0, 0, 32'd0, 1000, "frame 07");
    idle_check(1, "idle after 07");
    start_frame(1'b0, 32'h03);
    run_checks(1'b0, 0, 32'd0, 1000, "frame 03");
    idle_check(1, "idle after 03");

    // Abort during the first cycle of bit index 4 (cycle 8 after acceptance).
    start_frame(1'b0, 32'h5A);
    run_checks(1'b0, 0, 32'd0, 8, "pre-reset");
    exp_q.delete();
    word_q.delete();
    rst    = 1'b0;
    valid8 = 1'b0;
    #1;
    check_vec(obs(1'b0), IDLE_VEC, "async reset mid-frame");
    idle_check(3, "held in reset");
    rst = 1'b1;
    idle_check(3, "no done after reset");
    start_frame(1'b0, 32'hFF);
    run_checks(1'b0, 0, 32'd0, 1000, "frame FF after reset");
    idle_check(1, "idle after FF");

    start_frame(1'b1, 32'h9);
    run_checks(1'b1, 2, 32'h6, 1000, "dw4 frame 9");
    idle_check(2, "idle after dw4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptosda_n.md
PTOSDA_N -- requirements
Module: ptosda_n

Interface
REQ-001 Parameter: DW, default 8, number of payload bits per frame; legal range 2..32.
REQ-002 Ports (name direction width meaning), clock and reset first:
- sclk input 1: clock; all state changes on posedge.
- rst input 1: reset, asynchronous, active-low.
- data_in input DW: parallel payload word.
- valid input 1: data_in is valid.
- ready output 1: block can accept a word.
- scl output 1: serial clock.
- sda output 1: serial data.
- busy output 1: a frame is in progress.
- done output 1: one-cycle pulse at frame completion.
REQ-003 All outputs SHALL be registered, with no combinational path from an input to an output.

Function
REQ-004 States SHALL be IDLE, START, BIT, PAR, STOP.
REQ-005 In IDLE the outputs SHALL be scl=1, sda=1, ready=1, busy=0.
REQ-006 A word SHALL be accepted on the posedge where valid=1 and ready=1.
- data_in is captured into an internal shift register.
- Next state is START.
- ready=0 and busy=1 from the next cycle.
REQ-007 START SHALL last 1 cycle, with scl=1 and sda=0, which forms the start condition.
REQ-008 Entering BIT, the bit index SHALL load DW-1.
REQ-009 Each bit in BIT SHALL last 2 cycles, sent MSB first:
- cycle A: scl=0, sda=bit;
- cycle B: scl=1, sda=bit.
- sda SHALL change only while scl=0.
REQ-010 After cycle B of bit index 0, the next state SHALL be PAR when PTOSDA_PARITY_EN is defined, else STOP.
REQ-011 STOP SHALL last 3 cycles:
- (scl=0, sda=0)
- (scl=1, sda=0)
- (scl=1, sda=1): sda rises while scl is high, which forms the stop condition.
- The next state is then IDLE.
REQ-012 done SHALL be 1 for exactly the first IDLE cycle after STOP, coincident with ready returning to 1; otherwise done=0.
REQ-013 Frame latency, counted in cycles after the accepting edge:
- START occupies cycle 1.
- Bits occupy cycles 2..2*DW+1.
- STOP occupies the following 3 cycles.
- done follows STOP.
- For DW=8 without parity, done is high in cycle 21.
REQ-014 While busy=1, changes on valid and data_in SHALL be ignored and the captured word SHALL be unaffected.
REQ-015 Back-to-back: if valid is held high, the next word SHALL be accepted on the done cycle's edge. This guarantees exactly one idle cycle (scl=1, sda=1) between frames.
REQ-016 The bit index SHALL never wrap; the BIT to PAR/STOP transition SHALL occur only at index 0.
REQ-017 Unreachable state encodings SHALL return to IDLE on the next edge with the IDLE outputs.

Reset
REQ-018 On rst=0, asynchronously and regardless of state:
- outputs go to scl=1, sda=1, ready=1, busy=0, done=0;
- state goes to IDLE;
- the shift register and bit index clear to 0.
REQ-019 A reset mid-frame SHALL abandon the frame and assert no done pulse. The first frame after rst deasserts SHALL begin only on a new valid/ready handshake.

Configuration
REQ-020 Macro PTOSDA_PARITY_EN:
- Defined: PAR state is compiled in. It lasts 2 cycles, (scl=0, sda=P) then (scl=1, sda=P), where P is the even parity (XOR) of the captured DW bits. Frame length grows by 2 cycles.
- Undefined: no PAR state or parity logic exists, and BIT proceeds directly to STOP.

Verification
REQ-021 Reset, then hold idle for 10 cycles -> scl=1, sda=1, ready=1, busy=0, done=0 throughout.
REQ-022 DW=8, no parity, send 8'hA5 -> the following sequence:
- sda falls while scl=1;
- bits 1,0,1,0,0,1,0,1 sampled on scl rising edges;
- stop condition;
- done pulse in cycle 21 after acceptance.
REQ-023 DW=8 with PTOSDA_PARITY_EN, send 8'h07 -> parity bit 1 after bit 0; send 8'h03 -> parity bit 0; done in cycle 23.
REQ-024 valid held high with words 8'h3C then 8'hC3 -> second accepted on the done edge; exactly one idle cycle separates the stop and start conditions; both payloads are correct.
REQ-025 Assert rst during bit index 4 of a frame -> immediate scl=1, sda=1, ready=1, with no done pulse. Then send 8'hFF -> a clean, complete frame.
REQ-026 DW=4, change data_in mid-frame from 4'h9 to 4'h6 -> serial output remains 1,0,0,1.
